// File: rtl/wb_arb_pkg.sv
// Shared types, cycle-type constants and helpers for the Wishbone round-robin arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Index of the set bit; callers guarantee at most one bit is high.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin picker: first requester above 'last', wrapping around.
module wb_arb_rr_pick #(
  parameter int NUM_MASTERS = 3
) (
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic [$clog2(NUM_MASTERS)-1:0] last,
  output logic [NUM_MASTERS-1:0]         gnt,
  output logic                           valid
);

  always_comb begin
    int idx;
    idx   = 0;
    gnt   = '0;
    valid = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: holds the slave for a whole cyc, with a
// watchdog that aborts unresponsive slave cycles with an err to the owner.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int aw          = 32,
  parameter int dw          = 32,
  parameter int TIMEOUT     = 1024
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [NUM_MASTERS*aw-1:0]   wbm_adr_i,
  input  logic [NUM_MASTERS*dw-1:0]   wbm_dat_i,
  input  logic [NUM_MASTERS*dw/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
  output logic [dw-1:0]               wbm_dat_o,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,
  output logic [NUM_MASTERS-1:0]      wbm_rty_o,
  output logic [aw-1:0]               wbs_adr_o,
  output logic [dw-1:0]               wbs_dat_o,
  output logic [dw/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [dw-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o
);

  localparam int LW = $clog2(NUM_MASTERS);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SW = dw / 8;

  state_t                 state_reg, state_next;
  logic [NUM_MASTERS-1:0] grant_reg, grant_next;
  logic [LW-1:0]          last_reg, last_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic                   err_pulse_reg, err_pulse_next;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic                   pick_valid;
  logic                   owner_cyc, owner_stb, own, resp_en, slave_resp;

  wb_arb_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req   (wbm_cyc_i),
    .last  (last_reg),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // AND-OR mux of the owner's request; grant_reg is one-hot or zero.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_reg[i]) begin
        wbs_adr_o = wbs_adr_o | wbm_adr_i[i*aw +: aw];
        wbs_dat_o = wbs_dat_o | wbm_dat_i[i*dw +: dw];
        wbs_sel_o = wbs_sel_o | wbm_sel_i[i*SW +: SW];
        wbs_we_o  = wbs_we_o  | wbm_we_i[i];
        wbs_cti_o = wbs_cti_o | wbm_cti_i[i*3 +: 3];
        wbs_bte_o = wbs_bte_o | wbm_bte_i[i*2 +: 2];
      end
    end
  end

  assign owner_cyc  = |(grant_reg & wbm_cyc_i);
  assign owner_stb  = |(grant_reg & wbm_stb_i);
  assign own        = (state_reg == OWN);
  assign wbs_cyc_o  = own & owner_cyc;
  assign wbs_stb_o  = own & owner_cyc & owner_stb;
  assign resp_en    = wbs_cyc_o;
  assign slave_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

  assign wbm_dat_o = wbs_dat_i;
  assign wbm_ack_o = grant_reg & {NUM_MASTERS{resp_en & wbs_ack_i}};
  assign wbm_rty_o = grant_reg & {NUM_MASTERS{resp_en & wbs_rty_i}};
  assign wbm_err_o = grant_reg & {NUM_MASTERS{(resp_en & wbs_err_i) |
                                              ((state_reg == ABORT) & err_pulse_reg)}};
  assign grant_o   = grant_reg;

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    last_next      = last_reg;
    cnt_next       = cnt_reg;
    err_pulse_next = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (pick_valid) begin
          state_next = OWN;
          grant_next = pick_gnt;
          last_next  = LW'(onehot_to_idx(8'(pick_gnt)));
        end
      end
      OWN: begin
        if (!owner_cyc) begin
          state_next = IDLE;
          grant_next = '0;
          cnt_next   = '0;
        end else if (!owner_stb || slave_resp) begin
          cnt_next = '0;
        end else if (TIMEOUT != 0) begin
          // A response in the final cycle is handled above, so it wins over the abort.
          if (cnt_reg == CW'(TIMEOUT - 1)) begin
            state_next     = ABORT;
            cnt_next       = CW'(TIMEOUT);
            err_pulse_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      ABORT: begin
        if (!owner_cyc) begin
          state_next = IDLE;
          grant_next = '0;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      last_reg      <= LW'(NUM_MASTERS - 1);
      cnt_reg       <= '0;
      err_pulse_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      last_reg      <= last_next;
      cnt_reg       <= cnt_next;
      err_pulse_reg <= err_pulse_next;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: 3 masters, TIMEOUT=8, hand-computed expectations.
module tb_wb_rr_arbiter;
  import wb_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N*AW-1:0]   m_adr = '0;
  logic [N*DW-1:0]   m_dat = '0;
  logic [N*DW/8-1:0] m_sel = '1;
  logic [N-1:0]      m_we = '0, m_cyc = '0, m_stb = '0;
  logic [N*3-1:0]    m_cti = '0;
  logic [N*2-1:0]    m_bte = '0;
  logic [DW-1:0]     m_dat_o;
  logic [N-1:0]      m_ack, m_err, m_rty, grant;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_dat_o;
  logic [DW/8-1:0]   s_sel;
  logic              s_we, s_cyc, s_stb;
  logic [2:0]        s_cti;
  logic [1:0]        s_bte;
  logic [DW-1:0]     s_dat_i = '0;
  logic              s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;

  int total = 0;
  int bad   = 0;

  wb_rr_arbiter #(.NUM_MASTERS(N), .aw(AW), .dw(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel),
    .wbm_we_i(m_we), .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb),
    .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
    .wbm_dat_o(m_dat_o), .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
    .wbs_adr_o(s_adr), .wbs_dat_o(s_dat_o), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
    .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
    .wbs_dat_i(s_dat_i), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic req(input int i, input logic on, input logic [2:0] cti);
    m_cyc[i] = on;
    m_stb[i] = on;
    m_cti[i*3 +: 3] = cti;
  endtask

  initial begin
    int order [4];
    order = '{0, 1, 2, 0};

    // Reset values
    tick; tick;
    chk("rst_grant", 64'(grant), 64'(3'b000));
    chk("rst_cyc",   64'(s_cyc), 64'(1'b0));
    chk("rst_ack",   64'(m_ack), 64'(3'b000));
    rst = 1'b0;

    // 1: single read by master 1
    m_adr[1*AW +: AW] = 32'h100;
    req(1, 1'b1, CTI_CLASSIC);
    settle;
    chk("t1_lat_cyc", 64'(s_cyc), 64'(1'b0));
    tick;
    chk("t1_cyc",   64'(s_cyc), 64'(1'b1));
    chk("t1_adr",   64'(s_adr), 64'(32'h100));
    chk("t1_grant", 64'(grant), 64'(3'b010));
    s_ack = 1'b1; s_dat_i = 32'hDEADBEEF;
    settle;
    chk("t1_ack", 64'(m_ack),   64'(3'b010));
    chk("t1_dat", 64'(m_dat_o), 64'(32'hDEADBEEF));
    tick;
    s_ack = 1'b0;
    req(1, 1'b0, CTI_CLASSIC);
    settle;
    chk("t1_drop_cyc", 64'(s_cyc), 64'(1'b0));
    tick;
    chk("t1_idle_grant", 64'(grant), 64'(3'b000));

    // 2: three masters requesting continuously, after a fresh reset
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int m = 0; m < N; m++) req(m, 1'b1, CTI_CLASSIC);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk($sformatf("t2_grant%0d", k), 64'(grant), 64'(3'b001 << order[k]));
      chk($sformatf("t2_cyc%0d", k), 64'(s_cyc), 64'(1'b1));
      s_ack = 1'b1;
      settle;
      chk($sformatf("t2_ack%0d", k), 64'(m_ack), 64'(3'b001 << order[k]));
      tick;
      s_ack = 1'b0;
      req(order[k], 1'b0, CTI_CLASSIC);
      settle;
      chk($sformatf("t2_gap_cyc%0d", k), 64'(s_cyc), 64'(1'b0));
      tick;
      chk($sformatf("t2_idle%0d", k), 64'(grant), 64'(3'b000));
      req(order[k], 1'b1, CTI_CLASSIC);
    end
    for (int m = 0; m < N; m++) req(m, 1'b0, CTI_CLASSIC);

    // 3: 4-beat INCR burst by master 0 while master 2 waits
    tick;
    req(0, 1'b1, CTI_INCR);
    tick;
    chk("t3_grant0", 64'(grant), 64'(3'b001));
    req(2, 1'b1, CTI_CLASSIC);
    for (int b = 0; b < 4; b++) begin
      m_cti[0 +: 3] = (b == 3) ? CTI_EOB : CTI_INCR;
      s_ack = 1'b1;
      settle;
      chk($sformatf("t3_cti%0d", b), 64'(s_cti), 64'((b == 3) ? CTI_EOB : CTI_INCR));
      chk($sformatf("t3_ack%0d", b), 64'(m_ack), 64'(3'b001));
      tick;
    end
    s_ack = 1'b0;
    req(0, 1'b0, CTI_CLASSIC);
    settle;
    chk("t3_drop_cyc",  64'(s_cyc), 64'(1'b0));
    chk("t3_drop_gnt",  64'(grant), 64'(3'b001));
    tick;
    chk("t3_idle",      64'(grant), 64'(3'b000));
    tick;
    chk("t3_grant2",    64'(grant), 64'(3'b100));
    s_ack = 1'b1;
    tick;
    s_ack = 1'b0;
    req(2, 1'b0, CTI_CLASSIC);
    tick;

    // 4: watchdog abort on master 1, master 0 waiting
    req(1, 1'b1, CTI_CLASSIC);
    tick;
    chk("t4_grant1", 64'(grant), 64'(3'b010));
    req(0, 1'b1, CTI_CLASSIC);
    for (int c = 0; c < 7; c++) tick;
    chk("t4_c8_cyc", 64'(s_cyc), 64'(1'b1));
    chk("t4_c8_err", 64'(m_err), 64'(3'b000));
    tick;
    chk("t4_abort_cyc", 64'(s_cyc), 64'(1'b0));
    chk("t4_abort_stb", 64'(s_stb), 64'(1'b0));
    chk("t4_abort_err", 64'(m_err), 64'(3'b010));
    tick;
    chk("t4_err_once", 64'(m_err), 64'(3'b000));
    chk("t4_hold_gnt", 64'(grant), 64'(3'b010));
    req(1, 1'b0, CTI_CLASSIC);
    tick;
    chk("t4_idle", 64'(grant), 64'(3'b000));
    tick;
    chk("t4_next_grant", 64'(grant), 64'(3'b001));

    // 5: master 0 owns; slave acks exactly on the 8th stb cycle
    for (int c = 0; c < 7; c++) tick;
    s_ack = 1'b1;
    settle;
    chk("t5_ack", 64'(m_ack), 64'(3'b001));
    chk("t5_err", 64'(m_err), 64'(3'b000));
    tick;
    s_ack = 1'b0;
    settle;
    chk("t5_own_cyc", 64'(s_cyc), 64'(1'b1));
    chk("t5_own_err", 64'(m_err), 64'(3'b000));
    chk("t5_own_gnt", 64'(grant), 64'(3'b001));
    for (int c = 0; c < 6; c++) tick;
    chk("t5_cleared_cyc", 64'(s_cyc), 64'(1'b1));
    s_ack = 1'b1;
    tick;
    s_ack = 1'b0;
    req(0, 1'b0, CTI_CLASSIC);
    tick;

    // 6: reset in the middle of master 2's cycle
    req(2, 1'b1, CTI_INCR);
    tick;
    chk("t6_grant2", 64'(grant), 64'(3'b100));
    rst = 1'b1;
    s_ack = 1'b1;
    tick;
    chk("t6_rst_cyc", 64'(s_cyc), 64'(1'b0));
    chk("t6_rst_gnt", 64'(grant), 64'(3'b000));
    chk("t6_rst_ack", 64'(m_ack), 64'(3'b000));
    rst = 1'b0;
    s_ack = 1'b0;
    for (int m = 0; m < N; m++) req(m, 1'b1, CTI_CLASSIC);
    tick;
    chk("t6_grant0", 64'(grant), 64'(3'b001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Round-robin Wishbone B3 arbiter that shares one slave port between NUM_MASTERS masters. Its first use is putting the or1k data bus, the debug master and a future DMA master in front of the single g18 flash / sysram port. It holds the grant for a whole cycle (cyc high), so bursts and read-modify-write sequences are never split. A built-in watchdog terminates any slave that never responds with an err to the owning master.

Parameters:
NUM_MASTERS, 3, number of requesting masters (2..8).
aw, 32, address width.
dw, 32, data width; sel width is dw/8.
TIMEOUT, 1024, number of cycles with stb high and no slave response before abort; 0 disables the watchdog.

Ports:
wb_clk_i  in  1  clock; all logic is on the rising edge.
wb_rst_i  in  1  synchronous reset, active-high.
wbm_adr_i  in  NUM_MASTERS*aw  packed master addresses; master i occupies slice i.
wbm_dat_i  in  NUM_MASTERS*dw  packed master write data.
wbm_sel_i  in  NUM_MASTERS*dw/8  packed byte selects.
wbm_we_i, wbm_cyc_i, wbm_stb_i  in  NUM_MASTERS each  per-master control.
wbm_cti_i  in  NUM_MASTERS*3  packed cycle type.
wbm_bte_i  in  NUM_MASTERS*2  packed burst type.
wbm_dat_o  out  dw  slave read data, broadcast to all masters.
wbm_ack_o, wbm_err_o, wbm_rty_o  out  NUM_MASTERS each  responses; only the owner's bit can be high.
wbs_adr_o  out  aw  to slave.
wbs_dat_o  out  dw  to slave.
wbs_sel_o  out  dw/8  to slave.
wbs_we_o, wbs_cyc_o, wbs_stb_o  out  1 each  to slave.
wbs_cti_o  out  3  to slave.
wbs_bte_o  out  2  to slave.
wbs_dat_i  in  dw  from slave.
wbs_ack_i, wbs_err_i, wbs_rty_i  in  1 each  from slave.
grant_o  out  NUM_MASTERS  one-hot owner, for debug; all-zero when no master owns the slave.

Behaviour:
- States:
  - IDLE: no owner.
  - OWN: owner is registered.
  - ABORT: watchdog has fired.
- Reset values (at the next edge with wb_rst_i high):
  - state = IDLE, grant_o = 0, wbs_cyc_o = wbs_stb_o = 0.
  - All wbm ack/err/rty = 0; watchdog count = 0.
  - last = NUM_MASTERS-1, so master 0 has highest priority after reset.
  - A reset mid-burst drops the slave cycle immediately, with no response to the master.
- IDLE -> OWN: when any wbm_cyc_i is high, pick the first requester scanning from last+1 upward with wrap-around. Register grant_o and set last = winner.
- Arbitration latency is one cycle: a master's cyc in cycle N gives wbs_cyc_o in cycle N+1.
- OWN routing:
  - The slave-side outputs are a combinational mux of the owner's inputs.
  - wbs_cyc_o = owner cyc; wbs_stb_o = owner stb.
  - Slave ack/err/rty are routed only to the owner's bit.
- OWN -> IDLE: in the cycle the owner's cyc is low, the slave outputs are low and grant_o clears on the next edge.
  - A different master's request is granted no earlier than the following cycle, so there is at least one idle slave cycle between owners.
  - Requests from other masters during OWN are ignored, not queued. They stay pending because cyc stays high.
- Watchdog (TIMEOUT > 0):
  - Counts cycles with owner stb high and no slave ack/err/rty.
  - Clears on any slave response, or when stb is low.
  - When the count reaches TIMEOUT: go to ABORT and force wbs_cyc_o/wbs_stb_o low.
  - Drive the owner's wbm_err_o high for exactly one cycle (the first ABORT cycle).
  - Stay in ABORT until the owner's cyc is low, then go to IDLE.
- Simultaneous events:
  - A slave response in the same cycle the count would reach TIMEOUT wins: it is forwarded normally and the count clears.
  - The owner dropping cyc while another master raises cyc: go to IDLE first, then grant by round robin.
- Width rules: the count is $clog2(TIMEOUT+1) bits and saturates in ABORT. Slices are indexed i*aw +: aw, and so on.

Decomposition:
- Package wb_arb_pkg holds:
  - state enum {IDLE, OWN, ABORT};
  - CTI constants (CLASSIC = 3'b000, INCR = 3'b010, EOB = 3'b111);
  - function onehot_to_idx.
- Sub-module wb_arb_rr_pick: combinational round-robin picker. Inputs are req[NUM_MASTERS] and last index; outputs are one-hot gnt and valid.

Test Plan:
1. Reset, then master 1 raises cyc/stb, read of adr 0x100, slave acks with 0xDEADBEEF -> wbs_cyc_o high 1 cycle later; wbm_ack_o = 3'b010; wbm_dat_o = 0xDEADBEEF; grant_o = 0 the cycle after cyc drops.
2. Masters 0, 1 and 2 request continuously with single-beat cycles -> grant sequence 0, 1, 2, 0, with one idle slave cycle between grants.
3. Master 0 runs a 4-beat INCR burst (cti 010, 010, 010, 111) while master 2 requests -> all 4 acks go to master 0 uninterrupted; master 2 is granted only after master 0's cyc drops.
4. TIMEOUT = 8, slave never acks -> after 8 stb cycles, wbs_cyc_o = 0 and the owner gets a single-cycle err; the next requester is granted after the owner drops cyc.
5. TIMEOUT = 8, slave acks exactly on cycle 8 -> ack is forwarded, no err, state remains OWN.
6. wb_rst_i asserted mid-burst -> wbs_cyc_o = 0 and grant_o = 0 at the next edge; afterwards master 0 wins a simultaneous 0/1/2 request.
